// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared encodings for the LED pattern controller
package led_ctrl_pkg;

   localparam logic [1:0] MODE_ROTL   = 2'd0;
   localparam logic [1:0] MODE_ROTR   = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   localparam logic [1:0] SPEED_MIN = 2'd0;
   localparam logic [1:0] SPEED_MAX = 2'd3;

   // Seeds are width-independent shapes; the top expands them to LED_W bits.
   localparam logic [1:0] SEED_LSB = 2'd0;
   localparam logic [1:0] SEED_MSB = 2'd1;
   localparam logic [1:0] SEED_ALL = 2'd2;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   function automatic logic [1:0] next_mode(input logic [1:0] m);
      return m + 2'd1;
   endfunction

   function automatic logic [1:0] seed_kind(input logic [1:0] m);
      logic [1:0] k;
      case (m)
         MODE_ROTR:  k = SEED_MSB;
         MODE_BLINK: k = SEED_ALL;
         default:    k = SEED_LSB;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - step divider, period TIME_BASE >> speed
module led_step_timer #(
   parameter int TIME_BASE = 50000000,
   parameter int CNT_W     = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       clear,
   input  logic [1:0] speed,
   output logic       cnt_end
);

   localparam logic [CNT_W-1:0] LAST0 = CNT_W'(TIME_BASE - 1);
   localparam logic [CNT_W-1:0] LAST1 = CNT_W'((TIME_BASE >> 1) - 1);
   localparam logic [CNT_W-1:0] LAST2 = CNT_W'((TIME_BASE >> 2) - 1);
   localparam logic [CNT_W-1:0] LAST3 = CNT_W'((TIME_BASE >> 3) - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;

   always_comb begin
      case (speed)
         2'd0:    last = LAST0;
         2'd1:    last = LAST1;
         2'd2:    last = LAST2;
         default: last = LAST3;
      endcase
   end

   assign cnt_end = run && (cnt == last);

   // Holding while not running lets a resume continue the current period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || cnt_end) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - running-light controller with mode, speed and pause keys
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int LED_W     = 12,
   parameter int TIME_BASE = 50000000,
   parameter int CNT_W     = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_mode,
   input  logic             key_up,
   input  logic             key_dn,
   input  logic             key_pause,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic [1:0]       speed,
   output logic             paused,
   output logic             step
);

   localparam logic ST_RUN   = 1'b0;
   localparam logic ST_PAUSE = 1'b1;

   logic             state;
   dir_e             dir;
   dir_e             dir_nxt;
   logic [LED_W-1:0] led_nxt;
   logic             run;
   logic             spd_inc;
   logic             spd_dec;
   logic             clear;
   logic             cnt_end;
   logic             do_step;
   logic [1:0]       mode_nxt;

   function automatic logic [LED_W-1:0] seed_of(input logic [1:0] m);
      logic [LED_W-1:0] s;
      case (seed_kind(m))
         SEED_MSB: s = {1'b1, {(LED_W-1){1'b0}}};
         SEED_ALL: s = {LED_W{1'b1}};
         default:  s = {{(LED_W-1){1'b0}}, 1'b1};
      endcase
      return s;
   endfunction

   assign run      = (state == ST_RUN);
   assign paused   = (state == ST_PAUSE);
   assign mode_nxt = next_mode(mode);

   // Opposing keys cancel, and a saturated key is a no-op that must not disturb cnt.
   assign spd_inc = key_up & ~key_dn & (speed != SPEED_MAX);
   assign spd_dec = key_dn & ~key_up & (speed != SPEED_MIN);
   assign clear   = key_mode | spd_inc | spd_dec;
   assign do_step = cnt_end & ~clear;

   led_step_timer #(
      .TIME_BASE (TIME_BASE),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .clear   (clear),
      .speed   (speed),
      .cnt_end (cnt_end)
   );

   always_comb begin
      led_nxt = led;
      dir_nxt = dir;
      case (mode)
         MODE_ROTL: led_nxt = {led[LED_W-2:0], led[LED_W-1]};
         MODE_ROTR: led_nxt = {led[0], led[LED_W-1:1]};
         MODE_BOUNCE: begin
            // Turn around on the end LED so neither end is shown twice.
            if (dir == DIR_LEFT) begin
               if (led[LED_W-1]) begin
                  dir_nxt = DIR_RIGHT;
                  led_nxt = led >> 1;
               end else begin
                  led_nxt = led << 1;
               end
            end else begin
               if (led[0]) begin
                  dir_nxt = DIR_LEFT;
                  led_nxt = led << 1;
               end else begin
                  led_nxt = led >> 1;
               end
            end
         end
         default: led_nxt = ~led;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         mode  <= MODE_ROTL;
         speed <= SPEED_MIN;
         led   <= seed_of(MODE_ROTL);
         dir   <= DIR_LEFT;
         step  <= 1'b0;
      end else begin
         step <= do_step;
         if (key_pause) begin
            state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
         end
         if (spd_inc) begin
            speed <= speed + 2'd1;
         end else if (spd_dec) begin
            speed <= speed - 2'd1;
         end
         if (key_mode) begin
            mode <= mode_nxt;
            led  <= seed_of(mode_nxt);
            dir  <= DIR_LEFT;
         end else if (do_step) begin
            led <= led_nxt;
            dir <= dir_nxt;
         end
      end
   end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Controller for the 12-LED running-light bank. It sequences the LED pattern from a programmable step timer and four user controls: mode select, speed up, speed down and pause. The controls arrive as already-debounced single-cycle key pulses. The block sits between the key debounce logic and the board LED pins and replaces the fixed 1 s rotate-left runner. It adds mode, speed and pause control.

Parameters:
LED_W, 12, number of LEDs driven; must be >= 2.
TIME_BASE, 50000000, clock cycles per step at speed 0 (1 s at 50 MHz). Must satisfy TIME_BASE>>3 >= 2.
CNT_W, 26, step-counter width; must satisfy 2**CNT_W >= TIME_BASE.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
key_mode  input  1  single-cycle pulse: advance to next pattern mode
key_up  input  1  single-cycle pulse: faster (speed+1)
key_dn  input  1  single-cycle pulse: slower (speed-1)
key_pause  input  1  single-cycle pulse: toggle run/pause
led  output  LED_W  LED drive, 1 = on, registered
mode  output  2  current mode: 0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK
speed  output  2  current speed level 0..3
paused  output  1  1 while in PAUSE state
step  output  1  one-cycle pulse, high in the same cycle led shows a new step value

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - led = 1 (bit0 set); mode = 0; speed = 0; paused = 0; step = 0.
  - Counter = 0; bounce direction = left.
- Step period P = TIME_BASE >> speed. This gives TIME_BASE, /2, /4 and /8 cycles.
- Counter behaviour:
  - Increments each clk while RUN.
  - At cnt == P-1: cnt <= 0, and on the next edge led updates and step = 1 for that cycle. The first step after reset therefore appears exactly P cycles after reset release.
  - Holds its value in PAUSE.
- FSM states: RUN and PAUSE.
  - key_pause toggles RUN<->PAUSE.
  - In PAUSE: led is frozen, step = 0, counter holds. Resume continues from the held count; it does not restart the period.
- Pattern updates on each step:
  - ROTL: led <= {led[LED_W-2:0], led[LED_W-1]}.
  - ROTR: led <= {led[0], led[LED_W-1:1]}.
  - BOUNCE: one-hot shift in the current direction. When led[LED_W-1] is set and dir = left, flip dir to right and shift right. Mirror rule at led[0]. Sequence: 001,002,...,800,400,...,001,002,...
  - BLINK: led <= ~led. Seed is all ones.
- key_mode:
  - mode <= mode+1, wrapping 3->0.
  - led reloads the new mode's seed: ROTL 001, ROTR 800, BOUNCE 001 with dir = left, BLINK FFF.
  - cnt <= 0 and step = 0 that cycle.
  - Works in PAUSE too: the seed is loaded and the block stays paused.
- key_up: speed saturates at 3. key_dn: speed saturates at 0. Any actual speed change clears cnt to 0; a saturated no-op leaves cnt untouched.
- Simultaneous events:
  - key_up and key_dn in the same cycle: no speed change, cnt untouched.
  - key_mode in the same cycle as a count end: the reload wins and no step is produced.
  - A speed change in the same cycle as a count end: the step is suppressed and cnt = 0.
  - key_pause coincident with a count end in RUN: the step still happens and PAUSE is entered afterwards.
  - All keys are otherwise processed independently in the same cycle.
- Reset mid-operation: immediate return to the reset values, regardless of state.
- No combinational path from any input to any output.

Decomposition:
- Package led_ctrl_pkg: mode encodings (MODE_ROTL/ROTR/BOUNCE/BLINK), seed constants, and the speed min/max constants.
- Sub-module led_step_timer: programmable divider holding cnt.
  - Inputs: run, clear, speed.
  - Output: cnt_end pulse.
  - Parameters: TIME_BASE, CNT_W.
- The top level holds the FSM, the mode/speed registers and the pattern logic.

Test Plan:
- Sim with TIME_BASE=16, LED_W=12, no keys. Required: led = 001 during reset; first step at 16 cycles after release; led = 002, 004, ..., 800, 001 every 16 cycles; step high exactly on those cycles.
- key_up x4 then key_dn x5. Required: speed reaches 3 and saturates, then 0 and saturates. Step period measured as 2 cycles at speed 3 and 16 at speed 0. cnt is cleared on every real change.
- key_mode x2 to enter BOUNCE. Required: led = 001 immediately, then 002..800, 400..001, 002 with no repeat at the ends. One more key_mode gives led = FFF, 000, FFF, ... A fourth wraps to ROTL with led = 001.
- key_pause at count 5 of 16. Required: paused = 1 and led frozen for 100 cycles. key_pause again, then the next step arrives 11 cycles later.
- key_mode on the exact count-end cycle, and key_up+key_dn together. Required: in the first case the seed is loaded with no step pulse; in the second, speed and cnt are unchanged.
- Assert rst mid-BOUNCE at speed 2 while paused. Required: all outputs return to reset values at once; normal ROTL at 16 cycles per step after release.
